// File: rtl/line_clear_ctrl_if.sv
// Handshake and data bundle between the game FSM and the line clearer.
// The game FSM drives the master side; the clearer is the slave.
interface line_clear_ctrl_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  logic                 start;
  logic                 score_clr;
  logic [ROWS*COLS-1:0] map_in;
  logic                 busy;
  logic                 done;
  logic [ROWS*COLS-1:0] map_out;
  logic [4:0]           lines_cleared;
  logic [31:0]          score_out;

  modport master (
    output start,
    output score_clr,
    output map_in,
    input  busy,
    input  done,
    input  map_out,
    input  lines_cleared,
    input  score_out
  );

  modport slave (
    input  start,
    input  score_clr,
    input  map_in,
    output busy,
    output done,
    output map_out,
    output lines_cleared,
    output score_out
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Scans a locked playfield bottom-up, removes full lines,
// returns the compacted map and keeps a saturating score.
module line_clear_ctrl #(
  parameter int ROWS         = 20,
  parameter int COLS         = 10,
  parameter int TETRIS_BONUS = 4
) (
  input logic              clk,
  input logic              rst_n,
  line_clear_ctrl_if.slave bus
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(ROWS);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   work_q, work_d;
  logic [N-1:0]   map_q, map_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [4:0]     lines_q, lines_d;
  logic [31:0]    score_q, score_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           line_full;
  logic           drop_full;
  logic [N-1:0]   shifted;
  logic [31:0]    inc;
  logic [31:0]    base;
  logic [32:0]    sum;
  logic [31:0]    sat;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_up;

  // Full test on line ptr, and on line ptr-1 (the one a shift drops in).
  always_comb begin
    line_full = 1'b1;
    drop_full = (ptr_q != '0);
    idx       = '0;
    idx_up    = '0;
    for (int k = 0; k < COLS; k++) begin
      idx       = IW'(ptr_q) + IW'(ROWS * k);
      line_full = line_full & work_q[idx];
      if (ptr_q != '0) begin
        idx_up    = idx - IW'(1);
        drop_full = drop_full & work_q[idx_up];
      end
    end
  end

  always_comb begin
    shifted = work_q;
    for (int k = 0; k < COLS; k++) begin
      shifted[IW'(ROWS * k)] = 1'b0;
      for (int j = 1; j < ROWS; j++) begin
        if (PW'(j) <= ptr_q) begin
          shifted[IW'(j + ROWS * k)] =
            work_q[IW'(j - 1 + ROWS * k)];
        end
      end
    end
  end

  always_comb begin
    inc = 32'(cnt_q);
    if (cnt_q >= 5'd4) begin
      inc = inc + 32'(TETRIS_BONUS);
    end
    base = bus.score_clr ? 32'd0 : score_q;
    sum  = {1'b0, base} + {1'b0, inc};
    sat  = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    map_d   = map_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    score_d = bus.score_clr ? 32'd0 : score_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          work_d  = bus.map_in;
          ptr_d   = PW'(ROWS - 1);
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (line_full) begin
          state_d = SHIFT;
        end else if (ptr_q == '0) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q - PW'(1);
        end
      end
      // The dropped line is re-tested in the same cycle it lands.
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q + 5'd1;
        if (drop_full) begin
          state_d = SHIFT;
        end else if (ptr_q == '0) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q - PW'(1);
          state_d = SCAN;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        map_d   = work_q;
        lines_d = cnt_q;
        score_d = sat;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      map_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      score_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      map_q   <= map_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      score_q <= score_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.map_out       = map_q;
  assign bus.lines_cleared = lines_q;
  assign bus.score_out     = score_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Scoreboard bench for line_clear_ctrl: directed maps,
// expected results queued at issue and checked on done.
module tb_line_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int N    = ROWS * COLS;

  typedef struct {
    logic [N-1:0] map;
    logic [4:0]   lines;
    logic [31:0]  score;
    int           cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   ntot;
  int   npass;
  exp_t sb[$];

  line_clear_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  line_clear_ctrl #(
    .ROWS(ROWS),
    .COLS(COLS),
    .TETRIS_BONUS(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm,
                              logic [N-1:0] act,
                              logic [N-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s got=%0h want=%0h", nm, act, exp);
  endfunction

  function automatic logic [N-1:0] set_line(
    logic [N-1:0] m, int i, logic [COLS-1:0] pat);
    logic [N-1:0] r;
    r = m;
    for (int k = 0; k < COLS; k++) r[8'(i + ROWS * k)] = pat[k];
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        ntot++;
        $display("FAIL spurious_done at cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("map_out", bus.map_out, e.map);
        chk("lines", N'(bus.lines_cleared), N'(e.lines));
        chk("score", N'(bus.score_out), N'(e.score));
        chk("latency", N'(cyc), N'(e.cyc));
      end
    end
  end

  // xs: extra start sampled at start-edge+xs; xc: score_clr likewise.
  task automatic run_pass(input logic [N-1:0] m,
                          input logic [N-1:0] em,
                          input int nf,
                          input logic [31:0] es,
                          input int xs,
                          input int xc);
    exp_t e;
    bit   seen;
    @(negedge clk);
    bus.map_in = m;
    bus.start  = 1'b1;
    e.map   = em;
    e.lines = 5'(nf);
    e.score = es;
    e.cyc   = cyc + 1 + ROWS + nf + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 80 && !seen; i++) begin
      if (i == xs) bus.start = 1'b1;
      if (i == xc) bus.score_clr = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.score_clr = 1'b0;
      if (i == 1) chk("busy_mid", N'(bus.busy), N'(1));
      seen = bus.done;
    end
    if (!seen) begin
      ntot++;
      $display("FAIL timeout waiting for done");
      sb.delete();
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, N'(bus.busy), '0);
    chk({tag, "_done"}, N'(bus.done), '0);
    chk({tag, "_map"}, bus.map_out, '0);
    chk({tag, "_lines"}, N'(bus.lines_cleared), '0);
    chk({tag, "_score"}, N'(bus.score_out), '0);
  endtask

  logic [N-1:0] m, em, fl;

  initial begin
    ntot  = 0;
    npass = 0;
    rst_n = 1'b0;
    bus.start     = 1'b0;
    bus.score_clr = 1'b0;
    bus.map_in    = '0;
    fl = '1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // empty map; then start during the done cycle must be ignored
    run_pass('0, '0, 0, 32'd0, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    chk("start_on_done", N'(bus.busy), N'(0));

    // bottom line full plus one cell above it
    m  = set_line('0, 19, '1);
    m  = set_line(m, 18, 10'h008);
    em = set_line('0, 19, 10'h008);
    run_pass(m, em, 1, 32'd1, 0, 0);

    // tetris: lines 16..19
    m = '0;
    for (int i = 16; i < 20; i++) m = set_line(m, i, '1);
    run_pass(m, '0, 4, 32'd9, 0, 0);

    // split clear around a partial line
    m  = set_line('0, 10, '1);
    m  = set_line(m, 12, '1);
    m  = set_line(m, 11, 10'h155);
    em = set_line('0, 12, 10'h155);
    run_pass(m, em, 2, 32'd11, 0, 0);

    // restart pulse while busy is dropped
    m  = set_line('0, 19, '1);
    m  = set_line(m, 18, 10'h008);
    em = set_line('0, 19, 10'h008);
    run_pass(m, em, 1, 32'd12, 5, 0);
    repeat (30) @(negedge clk);

    // reset in the middle of a pass
    bus.map_in = fl;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("midrst_idle", N'(bus.busy), N'(0));

    // saturation from a preloaded score
    force dut.score_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.score_q;
    run_pass(m, em, 1, 32'hFFFF_FFFF, 0, 0);
    run_pass(m, em, 1, 32'hFFFF_FFFF, 0, 0);

    // clear coinciding with the DONE update
    m = set_line('0, 18, '1);
    m = set_line(m, 19, '1);
    run_pass(m, '0, 2, 32'd2, 0, 22);

    // fully set map
    run_pass(fl, '0, 20, 32'd26, 0, 0);

    // clear while idle
    @(negedge clk);
    bus.score_clr = 1'b1;
    @(negedge clk);
    bus.score_clr = 1'b0;
    chk("idle_clr", N'(bus.score_out), '0);

    repeat (5) @(negedge clk);
    chk("sb_drained", N'(sb.size()), '0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
